// File: rtl/srff_event_scheduler.sv
// Sticky SR event flags with a round-robin valid/ready scheduler.
// Flags latch on set pulses and clear when the consumer accepts them.
module srff_event_scheduler #(
  parameter int N = 8,
  parameter logic [N-1:0] POR_VALUE = '0,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   set,
  input  logic [N-1:0]   mask,
  input  logic           flush,
  input  logic [N-1:0]   ovf_clr,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           vld_d;
  logic [IDW-1:0] id_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_d;
  logic [N-1:0]   pend_d;
  logic [N-1:0]   ovf_d;
  logic [N-1:0]   cand;
  logic [N-1:0]   ack_vec;
  logic           acc;
  logic           hit;
  logic [IDW-1:0] pick;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Rotating search from rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    cand = pending & ~mask;
    hit  = 1'b0;
    pick = '0;
    sum  = '0;
    idx  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!hit && cand[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  // Set outranks the accept-clear so a re-armed event is not lost.
  always_comb begin
    acc     = out_valid & out_ready;
    ack_vec = '0;
    if (acc) begin
      ack_vec[out_id] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
      ovf_d  = '0;
    end else begin
      pend_d = set | (pending & ~ack_vec);
      ovf_d  = (set & pending & ~ack_vec)
             | (overflow & ~ovf_clr);
    end
  end

  always_comb begin
    state_d = state_q;
    vld_d   = out_valid;
    id_d    = out_id;
    rr_d    = rr_ptr;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          vld_d   = 1'b1;
          id_d    = pick;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (acc) begin
          vld_d   = 1'b0;
          state_d = IDLE;
          if (out_id == IDW'(N-1)) begin
            rr_d = '0;
          end else begin
            rr_d = out_id + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      rr_d    = rr_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      rr_ptr    <= '0;
      pending   <= POR_VALUE;
      overflow  <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= vld_d;
      out_id    <= id_d;
      rr_ptr    <= rr_d;
      pending   <= pend_d;
      overflow  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_srff_event_scheduler.sv
// Bench for srff_event_scheduler: vector table, directed corners,
// and random traffic against a behavioural model.
module tb_srff_event_scheduler;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_set = '0;
  logic [7:0] s_mask = '0;
  logic       s_flush = 1'b0;
  logic [7:0] s_ovf_clr = '0;
  logic       s_ready = 1'b1;
  logic       out_valid;
  logic [2:0] out_id;
  logic [7:0] pending;
  logic [7:0] overflow;

  int n_chk = 0;
  int n_fail = 0;
  bit use_model = 0;

  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  bit         m_vld;
  int         m_id;
  int         m_rr;

  srff_event_scheduler #(.N(8), .POR_VALUE(8'h05)) dut (
    .clk(clk),
    .rst(rst),
    .set(s_set),
    .mask(s_mask),
    .flush(s_flush),
    .ovf_clr(s_ovf_clr),
    .out_valid(out_valid),
    .out_id(out_id),
    .out_ready(s_ready),
    .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] set;
    logic [7:0] mask;
    logic       ready;
    logic [7:0] pend;
    logic       vld;
    logic [2:0] id;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void mk(logic [7:0] st, logic [7:0] mk_,
                             logic rdy, logic [7:0] p,
                             logic v, logic [2:0] id);
    vec_t e;
    e.set = st; e.mask = mk_; e.ready = rdy;
    e.pend = p; e.vld = v; e.id = id;
    tbl.push_back(e);
  endfunction

  function automatic void model_reset();
    m_pend = 8'h05;
    m_ovf  = '0;
    m_vld  = 0;
    m_id   = 0;
    m_rr   = 0;
  endfunction

  // Behavioural view: flags as a bit set, offer as (valid, id).
  function automatic void model_step();
    logic [7:0] np;
    logic [7:0] no;
    bit acc;
    bit found;
    int j;
    acc = m_vld && s_ready;
    for (int i = 0; i < N; i++) begin
      bit acc_i;
      acc_i = acc && (m_id == i);
      if (s_flush) np[i] = 0;
      else if (s_set[i]) np[i] = 1;
      else if (acc_i) np[i] = 0;
      else np[i] = m_pend[i];
      if (s_flush) no[i] = 0;
      else if (s_set[i] && m_pend[i] && !acc_i) no[i] = 1;
      else if (s_ovf_clr[i]) no[i] = 0;
      else no[i] = m_ovf[i];
    end
    if (s_flush) begin
      m_vld = 0;
    end else if (m_vld) begin
      if (s_ready) begin
        m_vld = 0;
        m_rr = (m_id + 1) % N;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!found && m_pend[j] && !s_mask[j]) begin
          found = 1;
          m_vld = 1;
          m_id = j;
        end
      end
    end
    m_pend = np;
    m_ovf = no;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    if (use_model) begin
      chk("rnd_pending", pending, m_pend);
      chk("rnd_overflow", overflow, m_ovf);
      chk("rnd_valid", out_valid, m_vld);
      if (m_vld) chk("rnd_id", out_id, m_id);
    end
  endtask

  task automatic idle_in();
    s_set = '0; s_mask = '0; s_flush = 0;
    s_ovf_clr = '0;
  endtask

  task automatic chk_out(string n, logic [7:0] p, logic [7:0] o,
                         logic v, logic [2:0] id, bit cid);
    chk({n, "_pending"}, pending, p);
    chk({n, "_overflow"}, overflow, o);
    chk({n, "_valid"}, out_valid, v);
    if (cid) chk({n, "_id"}, out_id, id);
  endtask

  initial begin
    logic [7:0] ff;
    ff = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 8'h05, 8'h00, 0, 3'd0, 1);
    rst = 0;
    #2;
    chk_out("reset_rel", 8'h05, 8'h00, 0, 3'd0, 1);

    // POR grants, a set[7] to bring rr_ptr back to 0, then all-ones.
    mk(8'h00, 8'h00, 1, 8'h05, 1, 3'd0);
    mk(8'h00, 8'h00, 1, 8'h04, 0, 3'd0);
    mk(8'h00, 8'h00, 1, 8'h04, 1, 3'd2);
    mk(8'h00, 8'h00, 1, 8'h00, 0, 3'd2);
    mk(8'h00, 8'h00, 1, 8'h00, 0, 3'd2);
    mk(8'h80, 8'h00, 1, 8'h80, 0, 3'd2);
    mk(8'h00, 8'h00, 1, 8'h80, 1, 3'd7);
    mk(8'h00, 8'h00, 1, 8'h00, 0, 3'd7);
    mk(8'hFF, 8'h00, 1, 8'hFF, 0, 3'd7);
    for (int k = 0; k < N; k++) begin
      mk(8'h00, 8'h00, 1, ff << k, 1, 3'(k));
      mk(8'h00, 8'h00, 1, ff << (k + 1), 0, 3'(k));
    end
    mk(8'h81, 8'h00, 1, 8'h81, 0, 3'd7);
    mk(8'h00, 8'h00, 1, 8'h81, 1, 3'd0);
    mk(8'h00, 8'h00, 1, 8'h80, 0, 3'd0);
    mk(8'h00, 8'h00, 1, 8'h80, 1, 3'd7);
    mk(8'h00, 8'h00, 1, 8'h00, 0, 3'd7);

    foreach (tbl[i]) begin
      s_set = tbl[i].set;
      s_mask = tbl[i].mask;
      s_ready = tbl[i].ready;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].pend, 8'h00,
              tbl[i].vld, tbl[i].id, 1);
    end
    idle_in();

    // Overflow while id3 is held on offer.
    s_ready = 0; s_set = 8'h08; tick();
    s_set = 8'h00; tick();
    chk_out("t3_offer", 8'h08, 8'h00, 1, 3'd3, 1);
    s_set = 8'h08; tick();
    chk_out("t3_ovf", 8'h08, 8'h08, 1, 3'd3, 1);
    s_set = 8'h00; s_ovf_clr = 8'h08; tick();
    chk_out("t3_ovfclr", 8'h08, 8'h00, 1, 3'd3, 1);
    s_ovf_clr = 8'h00; s_ready = 1; tick();
    chk_out("t3_acc", 8'h00, 8'h00, 0, 3'd0, 0);

    // Set racing an accept of the same id.
    s_ready = 0; s_set = 8'h20; tick();
    s_set = 8'h00; tick();
    chk_out("t4_offer", 8'h20, 8'h00, 1, 3'd5, 1);
    s_ready = 1; s_set = 8'h20; tick();
    chk_out("t4_race", 8'h20, 8'h00, 0, 3'd0, 0);
    s_set = 8'h00; tick();
    chk_out("t4_reoffer", 8'h20, 8'h00, 1, 3'd5, 1);
    tick();
    chk_out("t4_done", 8'h00, 8'h00, 0, 3'd0, 0);

    // Masked flags still latch but are skipped.
    s_ready = 0; s_mask = 8'h0F; s_set = 8'h11; tick();
    s_set = 8'h00; tick();
    chk_out("t5_offer4", 8'h11, 8'h00, 1, 3'd4, 1);
    s_ready = 1; tick();
    chk_out("t5_acc4", 8'h01, 8'h00, 0, 3'd0, 0);
    tick();
    chk_out("t5_masked", 8'h01, 8'h00, 0, 3'd0, 0);
    s_mask = 8'h00; tick();
    chk_out("t5_offer0", 8'h01, 8'h00, 1, 3'd0, 1);
    tick();
    chk_out("t5_acc0", 8'h00, 8'h00, 0, 3'd0, 0);

    // Flush during offer with a concurrent set.
    s_ready = 0; s_set = 8'h04; tick();
    s_set = 8'h00; tick();
    s_set = 8'h04; tick();
    chk_out("t6_pre", 8'h04, 8'h04, 1, 3'd2, 1);
    s_flush = 1; s_set = 8'h02; s_ready = 1; tick();
    chk_out("t6_flush", 8'h00, 8'h00, 0, 3'd0, 0);
    s_flush = 0; s_set = 8'h00; tick();
    chk_out("t6_after", 8'h00, 8'h00, 0, 3'd0, 0);

    // Async reset mid-offer.
    s_ready = 0; s_set = 8'h40; tick();
    s_set = 8'h00; tick();
    chk_out("rst_pre", 8'h40, 8'h00, 1, 3'd6, 1);
    #2;
    rst = 1;
    #1;
    chk_out("rst_mid", 8'h05, 8'h00, 0, 3'd0, 1);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();

    // Random traffic against the model.
    use_model = 1;
    for (int c = 0; c < 600; c++) begin
      s_set = '0;
      s_ovf_clr = '0;
      for (int i = 0; i < N; i++) begin
        s_set[i] = ($urandom_range(0, 7) == 0);
        s_ovf_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ((c % 16) == 0) s_mask = 8'($urandom) & 8'($urandom);
      s_flush = ($urandom_range(0, 39) == 0);
      s_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    use_model = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
